// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: arbitrates exceptions, interrupts and ERET for Status/EPC.
// Optional `CP0_EXC_TIMER_INT_EN adds a timer_int input ORed into IP7.
module cp0_exc_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] statusreg,
  input  logic [31:0] epc_in,
  input  logic [5:0]  hw_int,
  input  logic [1:0]  sw_ip,
`ifdef CP0_EXC_TIMER_INT_EN
  input  logic        timer_int,
`endif
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret_req,
  input  logic        flush_ack,
  output logic        exc_ack,
  output logic        flush_req,
  output logic        activeexception,
  output logic        eret,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic [4:0]  excode_out,
  output logic [7:0]  cause_ip,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_COMMIT,
    S_REDIR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic [5:0]  w_hw_sync;
  logic        w_ip7;
  logic        w_int_pend;
  logic        w_accept;
  logic        w_take_exc;
  logic        w_take_int;
  logic        w_take_eret;
  logic        r_is_eret;
  logic        r_old_exl;
  logic [31:0] r_epc_lat;
  logic [31:0] r_epc_out;
  logic [4:0]  r_excode;
  logic        w_unused_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], hw_int};
    end
  end

  assign w_hw_sync = r_sync[SYNC_STAGES-1];

`ifdef CP0_EXC_TIMER_INT_EN
  assign w_ip7 = timer_int | w_hw_sync[5];
`else
  assign w_ip7 = w_hw_sync[5];
`endif

  assign cause_ip = {w_ip7, w_hw_sync[4:0], sw_ip};

  assign w_int_pend = statusreg[0] & ~statusreg[1]
                    & (|(cause_ip & statusreg[15:8]));

  assign w_unused_ok = ^{statusreg[31:16], statusreg[7:2]};

  always_comb begin
    w_next      = r_state;
    w_take_exc  = 1'b0;
    w_take_int  = 1'b0;
    w_take_eret = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (exc_req)         w_take_exc  = 1'b1;
        else if (w_int_pend) w_take_int  = 1'b1;
        else if (eret_req)   w_take_eret = 1'b1;
        if (w_take_exc | w_take_int | w_take_eret)
          w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_ack) w_next = S_COMMIT;
      end
      S_COMMIT: w_next = S_REDIR;
      S_REDIR:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Qualified by reset so no accept pulse leaks out while reset is held
  assign w_accept = ~reset & (w_take_exc | w_take_int | w_take_eret);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_is_eret <= 1'b0;
      r_old_exl <= 1'b0;
      r_epc_lat <= '0;
      r_epc_out <= '0;
      r_excode  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_is_eret <= w_take_eret;
        r_old_exl <= statusreg[1];
        r_epc_lat <= epc_in;
        r_epc_out <= exc_pc;
        if (w_take_exc)      r_excode <= exc_code;
        else if (w_take_int) r_excode <= 5'd0;
      end
    end
  end

  assign exc_ack         = w_accept;
  assign busy            = (r_state != S_IDLE);
  assign flush_req       = (r_state == S_FLUSH);
  assign activeexception = (r_state == S_COMMIT) & ~r_is_eret;
  assign eret            = (r_state == S_COMMIT) & r_is_eret;
  // A nested exception (EXL already set) must not clobber EPC
  assign epc_we          = (r_state == S_COMMIT) & ~r_is_eret & ~r_old_exl;
  assign redirect_valid  = (r_state == S_REDIR);
  assign redirect_pc     = (r_state != S_REDIR) ? 32'd0 :
                           r_is_eret ? r_epc_lat : EXC_VECTOR;
  assign epc_out         = r_epc_out;
  assign excode_out      = r_excode;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] statusreg;
  logic [31:0] epc_in;
  logic [5:0]  hw_int;
  logic [1:0]  sw_ip;
`ifdef CP0_EXC_TIMER_INT_EN
  logic        timer_int;
`endif
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        eret_req;
  logic        flush_ack;
  logic        exc_ack;
  logic        flush_req;
  logic        activeexception;
  logic        eret;
  logic        epc_we;
  logic [31:0] epc_out;
  logic [4:0]  excode_out;
  logic [7:0]  cause_ip;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] VEC = 32'h8000_0180;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .statusreg       (statusreg),
    .epc_in          (epc_in),
    .hw_int          (hw_int),
    .sw_ip           (sw_ip),
`ifdef CP0_EXC_TIMER_INT_EN
    .timer_int       (timer_int),
`endif
    .exc_req         (exc_req),
    .exc_code        (exc_code),
    .exc_pc          (exc_pc),
    .eret_req        (eret_req),
    .flush_ack       (flush_ack),
    .exc_ack         (exc_ack),
    .flush_req       (flush_req),
    .activeexception (activeexception),
    .eret            (eret),
    .epc_we          (epc_we),
    .epc_out         (epc_out),
    .excode_out      (excode_out),
    .cause_ip        (cause_ip),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    statusreg = '0;
    epc_in    = '0;
    hw_int    = '0;
    sw_ip     = '0;
`ifdef CP0_EXC_TIMER_INT_EN
    timer_int = 1'b0;
`endif
    exc_req   = 1'b0;
    exc_code  = '0;
    exc_pc    = '0;
    eret_req  = 1'b0;
    flush_ack = 1'b1;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {exc_ack, flush_req, activeexception, eret,
                     epc_we, redirect_valid}, 0);
    chk("rst_epc", epc_out, 0);
    chk("rst_cause", cause_ip, 0);
    reset = 1'b0;
    tick();

    // Synchronous exception, EXL=0
    exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h400;
    #1;
    chk("exc_ack", exc_ack, 1);
    tick();
    exc_req = 1'b0;
    chk("exc_ack_pulse", exc_ack, 0);
    chk("exc_flush", flush_req, 1);
    chk("exc_epc_out", epc_out, 32'h400);
    chk("exc_code", excode_out, 4);
    tick();
    chk("exc_active", activeexception, 1);
    chk("exc_epc_we", epc_we, 1);
    chk("exc_no_eret", eret, 0);
    tick();
    chk("exc_redir_v", redirect_valid, 1);
    chk("exc_redir_pc", redirect_pc, VEC);
    chk("exc_active_off", activeexception, 0);
    tick();
    chk("exc_idle", busy, 0);

    // HW interrupt line 0, IE=1, IM[2]=1
    statusreg = 32'h0000_0401;
    hw_int    = 6'b000001;
    exc_pc    = 32'h500;
    tick();
    chk("int_sync1", cause_ip, 0);
    chk("int_noack1", exc_ack, 0);
    tick();
    chk("int_sync2", cause_ip, 8'h04);
    chk("int_ack", exc_ack, 1);
    hw_int = '0;
    tick();
    chk("int_flush", flush_req, 1);
    chk("int_code", excode_out, 0);
    chk("int_epc_out", epc_out, 32'h500);
    tick();
    chk("int_active", activeexception, 1);
    tick();
    chk("int_redir_pc", redirect_pc, VEC);
    tick();
    chk("int_idle", busy, 0);

    // Masked by IM
    statusreg = 32'h0000_0001;
    hw_int    = 6'b000001;
    tick(4);
    chk("im_cause", cause_ip, 8'h04);
    chk("im_noack", exc_ack, 0);
    chk("im_idle", busy, 0);
    // Masked by EXL
    statusreg = 32'h0000_0403;
    #1;
    chk("exl_noack", exc_ack, 0);
    tick(2);
    chk("exl_idle", busy, 0);
    // Software interrupt with IE=1, IM[0]=1
    hw_int    = '0;
    statusreg = 32'h0000_0100;
    tick(3);
    statusreg = 32'h0000_0101;
    sw_ip     = 2'b01;
    #1;
    chk("sw_cause", cause_ip, 8'h01);
    chk("sw_ack", exc_ack, 1);
    tick();
    sw_ip = '0;
    statusreg = '0;
    chk("sw_code", excode_out, 0);
    tick(3);
    chk("sw_idle", busy, 0);

    // ERET
    epc_in   = 32'h1234;
    eret_req = 1'b1;
    #1;
    chk("eret_ack", exc_ack, 1);
    tick();
    eret_req = 1'b0;
    epc_in   = 32'h9999;
    chk("eret_code_kept", excode_out, 0);
    tick();
    chk("eret_pulse", eret, 1);
    chk("eret_epc_we", epc_we, 0);
    chk("eret_no_active", activeexception, 0);
    tick();
    chk("eret_redir_pc", redirect_pc, 32'h1234);
    tick();

    // Nested exception with EXL=1
    statusreg = 32'h0000_0002;
    exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h600;
    tick();
    exc_req = 1'b0;
    chk("nest_code", excode_out, 10);
    tick();
    chk("nest_active", activeexception, 1);
    chk("nest_epc_we", epc_we, 0);
    tick(2);

    // Exception and ERET together: exception first, ERET stays pending
    statusreg = '0;
    epc_in   = 32'h2000;
    exc_req  = 1'b1; exc_code = 5'd8;
    eret_req = 1'b1;
    #1;
    chk("both_ack", exc_ack, 1);
    tick();
    exc_req = 1'b0;
    tick();
    chk("both_exc_first", activeexception, 1);
    chk("both_no_eret", eret, 0);
    tick();
    chk("both_redir_vec", redirect_pc, VEC);
    tick();
    chk("both_eret_ack", exc_ack, 1);
    tick();
    eret_req = 1'b0;
    tick();
    chk("both_eret", eret, 1);
    tick();
    chk("both_eret_pc", redirect_pc, 32'h2000);
    tick();

    // Flush stall then reset mid-sequence
    flush_ack = 1'b0;
    exc_req = 1'b1; exc_code = 5'd12; exc_pc = 32'h700;
    tick();
    exc_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_flush", flush_req, 1);
      chk("stall_pulses", {activeexception, eret, epc_we, redirect_valid}, 0);
      tick();
    end
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_flush", flush_req, 0);
    chk("midrst_epc", epc_out, 0);
    chk("midrst_code", excode_out, 0);
    tick();
    reset = 1'b0;
    flush_ack = 1'b1;
    tick();
    chk("midrst_idle", busy, 0);
    chk("midrst_nopulse", {activeexception, redirect_valid}, 0);

`ifdef CP0_EXC_TIMER_INT_EN
    statusreg = 32'h0000_8001;
    timer_int = 1'b1;
    #1;
    chk("tmr_cause", cause_ip, 8'h80);
    chk("tmr_ack", exc_ack, 1);
    tick();
    timer_int = 1'b0;
    statusreg = '0;
    tick(3);
    chk("tmr_idle", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
